paint_brush_writer: RTL and testbench

PAINT_BRUSH_WRITER -- requirements
Module: paint_brush_writer

---
 rtl/paint_brush_writer.sv | 184 ++++++++++++++++++
 tb/tb_paint_brush_writer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/paint_brush_writer.sv
// Square-brush pixel writer: paints a clipped (2r+1)x(2r+1) square or clears the
// whole frame, issuing one registered framebuffer write per cycle.
module paint_brush_writer #(
  parameter int N     = 19,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [9:0]   x,
  input  logic [8:0]   y,
  input  logic [2:0]   radius,
  input  logic [23:0]  color,
  input  logic         erase,
  input  logic         clear,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] wr_addr,
  output logic         wren,
  output logic [6:0]   wr_data
);

  typedef enum logic [1:0] {IDLE, STROKE, CLEAR, DONE} state_t;

  localparam logic [N-1:0]       H_RES_N   = N'(H_RES);
  localparam logic [N-1:0]       LAST_ADDR = N'(H_RES * V_RES - 1);
  localparam logic [9:0]         X_MAX     = 10'(H_RES - 1);
  localparam logic [8:0]         Y_MAX     = 9'(V_RES - 1);
  localparam logic signed [11:0] X_MAX_S   = 12'(H_RES - 1);
  localparam logic signed [11:0] Y_MAX_S   = 12'(V_RES - 1);

  state_t       state_q, state_d;
  logic [9:0]   px_q, px_d, x0_q, x0_d, x1_q, x1_d;
  logic [8:0]   py_q, py_d, y1_q, y1_d;
  logic [N-1:0] row_base_q, row_base_d;
  logic [N-1:0] wr_addr_q, wr_addr_d;
  logic [6:0]   wr_data_q, wr_data_d;
  logic         wren_q, wren_d, busy_q, busy_d, done_q, done_d;

  logic [2:0]         code;
  logic signed [11:0] xs, ys, rs, x_lo, x_hi, y_lo, y_hi;
  logic [9:0]         x0_c, x1_c;
  logic [8:0]         y0_c, y1_c;
  logic [N-1:0]       base_c;

  always_comb begin
    code = 3'd0;
    if (!erase) begin
      case (color)
        24'hFFFFFF: code = 3'd1;
        24'h000001: code = 3'd2;
        24'hFF0000: code = 3'd3;
        24'h0000FF: code = 3'd4;
        24'hFFFF00: code = 3'd5;
        24'h00FF00: code = 3'd6;
        24'hFF00FF: code = 3'd7;
        default:    code = 3'd0;
      endcase
    end
  end

  // Signed 12-bit bound arithmetic so x-r below zero cannot wrap.
  always_comb begin
    xs   = signed'({2'b00, x});
    ys   = signed'({3'b000, y});
    rs   = signed'({9'd0, radius});
    x_lo = xs - rs;
    x_hi = xs + rs;
    y_lo = ys - rs;
    y_hi = ys + rs;
    x0_c = (x_lo < 0) ? '0 : x_lo[9:0];
    x1_c = (x_hi > X_MAX_S) ? X_MAX : x_hi[9:0];
    y0_c = (y_lo < 0) ? '0 : y_lo[8:0];
    y1_c = (y_hi > Y_MAX_S) ? Y_MAX : y_hi[8:0];
    // Constant-coefficient product, only evaluated once per stroke launch.
    base_c = N'(y0_c) * H_RES_N;
  end

  always_comb begin
    state_d    = state_q;
    px_d       = px_q;
    py_d       = py_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    row_base_d = row_base_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wren_d     = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d   = CLEAR;
          wr_addr_d = '0;
          wr_data_d = '0;
          wren_d    = 1'b1;
          busy_d    = 1'b1;
        end else if (start) begin
          state_d    = STROKE;
          px_d       = x0_c;
          py_d       = y0_c;
          x0_d       = x0_c;
          x1_d       = x1_c;
          y1_d       = y1_c;
          row_base_d = base_c;
          wr_addr_d  = base_c + N'(x0_c);
          wr_data_d  = {4'd0, code};
          wren_d     = 1'b1;
          busy_d     = 1'b1;
        end
      end
      STROKE: begin
        if (px_q == x1_q && py_q == y1_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          wren_d = 1'b1;
          busy_d = 1'b1;
          if (px_q == x1_q) begin
            px_d       = x0_q;
            py_d       = py_q + 9'd1;
            row_base_d = row_base_q + H_RES_N;
            wr_addr_d  = row_base_d + N'(x0_q);
          end else begin
            px_d      = px_q + 10'd1;
            wr_addr_d = wr_addr_q + N'(1);
          end
        end
      end
      CLEAR: begin
        if (wr_addr_q == LAST_ADDR) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          wr_addr_d = wr_addr_q + N'(1);
          wren_d    = 1'b1;
          busy_d    = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      px_q       <= '0;
      py_q       <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      row_base_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wren_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      py_q       <= py_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      row_base_q <= row_base_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wren_q     <= wren_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wr_addr = wr_addr_q;
  assign wren    = wren_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_paint_brush_writer.sv
// Directed bench for paint_brush_writer: full-size instance for strokes and
// clear abort, small-frame instance for a complete clear.
module tb_paint_brush_writer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, clear, erase;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [2:0]  radius;
  logic [23:0] color;
  logic        busy, done, wren;
  logic [18:0] wr_addr;
  logic [6:0]  wr_data;

  logic        s_reset, s_start, s_clear;
  logic        s_busy, s_done, s_wren;
  logic [6:0]  s_wr_addr;
  logic [6:0]  s_wr_data;

  paint_brush_writer #(.N(19), .H_RES(640), .V_RES(480)) dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .y(y), .radius(radius),
    .color(color), .erase(erase), .clear(clear), .busy(busy), .done(done),
    .wr_addr(wr_addr), .wren(wren), .wr_data(wr_data)
  );

  paint_brush_writer #(.N(7), .H_RES(16), .V_RES(8)) dut_s (
    .clk(clk), .reset(s_reset), .start(s_start), .x(x), .y(y), .radius(radius),
    .color(color), .erase(erase), .clear(s_clear), .busy(s_busy), .done(s_done),
    .wr_addr(s_wr_addr), .wren(s_wren), .wr_data(s_wr_data)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] addrs[$];
  logic [31:0] datas[$];
  int busy_bad, busy_cnt, done_seen, done_bad, done_gap, first_wr, poke_at;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [9:0] lx, input logic [8:0] ly, input logic [2:0] lr,
                        input logic [23:0] lc, input logic le);
    x = lx; y = ly; radius = lr; color = lc; erase = le; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic collect(input int budget);
    int cyc = 0;
    int last_wr = -1;
    addrs.delete(); datas.delete();
    busy_bad = 0; busy_cnt = 0; done_seen = 0; done_bad = 0; done_gap = -1; first_wr = -1;
    while (cyc < budget) begin
      if (poke_at >= 0 && cyc == poke_at) begin
        start = 1'b1; clear = 1'b1; x = '0; y = '0; radius = 3'd7; color = 24'hFF00FF;
      end else begin
        start = 1'b0; clear = 1'b0;
      end
      if (wren) begin
        addrs.push_back(32'(wr_addr));
        datas.push_back(32'(wr_data));
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end
      if (busy) busy_cnt++;
      if (busy !== wren) busy_bad++;
      if (done) begin
        done_seen = 1;
        done_gap  = cyc - last_wr;
        if (wren !== 1'b0 || busy !== 1'b0) done_bad++;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    check("done_within_budget", 32'(done_seen), 32'd1);
    check("busy_eq_wren", 32'(busy_bad), 32'd0);
    check("done_quiet", 32'(done_bad), 32'd0);
    check("first_write_latency", 32'(first_wr), 32'd0);
    check("done_after_last_write", 32'(done_gap), 32'd1);
  endtask

  logic [23:0] ctab [8] = '{24'hFFFFFF, 24'h000001, 24'hFF0000, 24'h0000FF,
                            24'hFFFF00, 24'h00FF00, 24'hFF00FF, 24'h123457};
  int          codes[8] = '{1, 2, 3, 4, 5, 6, 7, 0};

  initial begin
    int bad, n, w, d;
    reset = 1'b1; start = 1'b1; clear = 1'b1; erase = 1'b0;
    x = '0; y = '0; radius = '0; color = '0; poke_at = -1;
    s_reset = 1'b1; s_start = 1'b0; s_clear = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wren", 32'(wren), 32'd0);
    check("rst_addr", 32'(wr_addr), 32'd0);
    check("rst_data", 32'(wr_data), 32'd0);
    reset = 1'b0; start = 1'b0; clear = 1'b0; s_reset = 1'b0;
    @(negedge clk);

    // Single pixel, red
    launch(10'd5, 9'd3, 3'd0, 24'hFF0000, 1'b0);
    collect(20);
    check("r0_count", 32'(addrs.size()), 32'd1);
    check("r0_addr", addrs[0], 32'd1925);
    check("r0_data", datas[0], 32'd3);
    @(negedge clk);
    check("r0_done_one_cycle", 32'(done), 32'd0);

    // Top-left clipped, green
    launch(10'd0, 9'd0, 3'd1, 24'h00FF00, 1'b0);
    collect(20);
    check("tl_count", 32'(addrs.size()), 32'd4);
    check("tl_busy_cycles", 32'(busy_cnt), 32'd4);
    check("tl_a0", addrs[0], 32'd0);
    check("tl_a1", addrs[1], 32'd1);
    check("tl_a2", addrs[2], 32'd640);
    check("tl_a3", addrs[3], 32'd641);
    bad = 0;
    foreach (datas[i]) if (datas[i] !== 32'd6) bad++;
    check("tl_data", 32'(bad), 32'd0);
    @(negedge clk);

    // Bottom-right clipped, unmapped colour
    launch(10'd639, 9'd479, 3'd2, 24'h123456, 1'b0);
    collect(30);
    check("br_count", 32'(addrs.size()), 32'd9);
    check("br_first", addrs[0], 32'd305917);
    check("br_last", addrs[addrs.size()-1], 32'd307199);
    bad = 0;
    foreach (datas[i]) if (datas[i] !== 32'd0) bad++;
    check("br_data", 32'(bad), 32'd0);
    @(negedge clk);

    // Colour encode table, r=0
    for (int i = 0; i < 8; i++) begin
      launch(10'd10, 9'd10, 3'd0, ctab[i], 1'b0);
      collect(10);
      check("encode", datas[0], 32'(codes[i]));
      @(negedge clk);
    end
    launch(10'd10, 9'd10, 3'd0, 24'hFF0000, 1'b1);
    collect(10);
    check("encode_erase", datas[0], 32'd0);
    @(negedge clk);

    // Full 7x7 stroke with start/clear/data poked mid-scan
    poke_at = 5;
    launch(10'd100, 9'd50, 3'd3, 24'hFFFF00, 1'b0);
    collect(100);
    poke_at = -1;
    check("poke_count", 32'(addrs.size()), 32'd49);
    bad = 0;
    foreach (addrs[i]) begin
      if (addrs[i] !== 32'((47 + i / 7) * 640 + 97 + i % 7)) bad++;
      if (datas[i] !== 32'd5) bad++;
    end
    check("poke_order_data", 32'(bad), 32'd0);
    @(negedge clk);
    check("hold_addr", 32'(wr_addr), 32'd34023);
    check("hold_data", 32'(wr_data), 32'd5);
    check("poke_no_restart", 32'(wren), 32'd0);
    @(negedge clk);
    check("poke_still_idle", 32'(wren), 32'd0);

    // Reset on the 10th write of an erase stroke, with start also high
    launch(10'd200, 9'd200, 3'd7, 24'hFFFFFF, 1'b1);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (wren) n++;
      if (n == 10) break;
      @(negedge clk);
    end
    check("abort_reached_10", 32'(n), 32'd10);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("abort_wren", 32'(wren), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_addr", 32'(wr_addr), 32'd0);
    w = 0; d = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (wren) w++;
      if (done) d++;
    end
    check("abort_no_writes", 32'(w), 32'd0);
    check("abort_no_done", 32'(d), 32'd0);
    launch(10'd5, 9'd3, 3'd0, 24'h0000FF, 1'b0);
    collect(10);
    check("after_abort_addr", addrs[0], 32'd1925);
    check("after_abort_data", datas[0], 32'd4);
    @(negedge clk);

    // Full-size clear with start: check head of the scan, then abort
    x = 10'd5; y = 9'd3; color = 24'hFF0000; erase = 1'b0;
    clear = 1'b1; start = 1'b1;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (wren !== 1'b1 || busy !== 1'b1 || 32'(wr_addr) !== 32'(i) || wr_data !== 7'd0) bad++;
      @(negedge clk);
    end
    check("clear_head", 32'(bad), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("clear_abort_wren", 32'(wren), 32'd0);
    d = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done || wren) d++;
    end
    check("clear_abort_quiet", 32'(d), 32'd0);

    // Small frame: complete clear with simultaneous start
    s_clear = 1'b1; s_start = 1'b1;
    @(negedge clk);
    s_clear = 1'b0; s_start = 1'b0;
    n = 0; bad = 0; d = 0;
    for (int c = 0; c < 300; c++) begin
      if (s_busy !== s_wren) bad++;
      if (s_wren) begin
        if (32'(s_wr_addr) !== 32'(n) || s_wr_data !== 7'd0) bad++;
        n++;
      end
      if (s_done) begin
        d = 1;
        if (s_wren || s_busy) bad++;
        break;
      end
      @(negedge clk);
    end
    check("sclear_count", 32'(n), 32'd128);
    check("sclear_order", 32'(bad), 32'd0);
    check("sclear_done", 32'(d), 32'd1);
    @(negedge clk);
    check("sclear_done_one_cycle", 32'(s_done), 32'd0);
    check("sclear_last_addr_held", 32'(s_wr_addr), 32'd127);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
